// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operand and result bus for alu_seq
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             ovf;
  modport master (
    output in_valid, a, b, opcode, cin, out_ready,
    input  in_ready, out_valid, result, cout, zero, ovf
  );
  modport slave (
    input  in_valid, a, b, opcode, cin, out_ready,
    output in_ready, out_valid, result, cout, zero, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes and a multi-cycle shift-add multiply
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d, result_q, result_d;
  logic [SW-1:0]      cnt_q, cnt_d, shamt;
  logic               cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH:0]     sum_w, diff_w, alu_w;
  logic               alu_ovf, accept;
  assign shamt    = bus.b[SW-1:0];
  assign sum_w    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign diff_w   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  // single-cycle ops; MUL is handled by the BUSY sequencer
  always_comb begin
    alu_w   = '0;
    alu_ovf = 1'b0;
    case (bus.opcode)
      3'b000: begin
        alu_w   = sum_w;
        alu_ovf = (bus.a[M] == bus.b[M]) && (sum_w[M] != bus.a[M]);
      end
      3'b001: begin
        alu_w   = diff_w;
        alu_ovf = (bus.a[M] != bus.b[M]) && (diff_w[M] != bus.a[M]);
      end
      3'b010:  alu_w = {1'b0, bus.a & bus.b};
      3'b011:  alu_w = {1'b0, bus.a | bus.b};
      3'b100:  alu_w = {1'b0, bus.a ^ bus.b};
      3'b110:  alu_w = {1'b0, bus.a << shamt};
      3'b111:  alu_w = {1'b0, bus.a >> shamt};
      default: alu_w = '0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SW'(1);
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = acc_step[WIDTH-1:0];
          cout_d   = |acc_step[2*WIDTH-1:WIDTH];
          zero_d   = acc_step[WIDTH-1:0] == '0;
          ovf_d    = 1'b0;
        end
      end
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // an accept in DONE overrides the return to IDLE, giving bubble-free back-to-back ops
    if (accept && bus.opcode == 3'b101) begin
      state_d  = BUSY;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, bus.a};
      mplier_d = bus.b;
      cnt_d    = '0;
    end else if (accept) begin
      state_d  = DONE;
      result_d = alu_w[WIDTH-1:0];
      cout_d   = alu_w[WIDTH];
      zero_d   = alu_w[WIDTH-1:0] == '0;
      ovf_d    = alu_ovf;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed corner cases and random traffic
module tb_alu_seq;
  localparam int W = 8;
  typedef struct {
    int         op;
    logic [W-1:0] r;
    logic       c;
    logic       z;
    logic       v;
    int         lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int   accq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rmode = 2;
  bit   rst_chk = 1'b0;
  bit   prev_hold = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(int op, int a, int b, int c);
    exp_t e;
    int sa, sbv, full, s;
    sa  = a > 127 ? a - 256 : a;
    sbv = b > 127 ? b - 256 : b;
    e.op = op;
    e.c = 1'b0;
    e.v = 1'b0;
    full = 0;
    case (op)
      0: begin
        full = a + b + c;
        e.c = full > 255;
        s = sa + sbv + c;
        e.v = (s > 127) || (s < -128);
      end
      1: begin
        full = a - b;
        e.c = a >= b;
        s = sa - sbv;
        e.v = (s > 127) || (s < -128);
      end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: begin
        full = a * b;
        e.c = full > 255;
      end
      6: full = a << (b % W);
      default: full = a >> (b % W);
    endcase
    e.r = 8'(full);
    e.z = e.r == 0;
    e.lat = op == 5 ? W + 1 : 1;
    return e;
  endfunction
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (rmode == 2) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end
  // monitor: checks handshake timing and pops the scoreboard on every output transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      accq.delete();
      sb.delete();
      rst_chk = 1'b1;
      prev_hold = 1'b0;
    end else begin
      if (rst_chk) begin
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_flags", {bus.cout, bus.zero, bus.ovf}, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        rst_chk = 1'b0;
      end
      chk("in_ready", bus.in_ready, bus.out_valid ? bus.out_ready : (accq.size() == 0));
      if (bus.out_valid) begin
        if (sb.size() == 0 || accq.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          if (!prev_hold) chk($sformatf("op%0d_latency", sb[0].op), cyc - accq[0], sb[0].lat);
          chk($sformatf("op%0d_result", sb[0].op), bus.result, sb[0].r);
          chk($sformatf("op%0d_cout", sb[0].op), bus.cout, sb[0].c);
          chk($sformatf("op%0d_zero", sb[0].op), bus.zero, sb[0].z);
          chk($sformatf("op%0d_ovf", sb[0].op), bus.ovf, sb[0].v);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            void'(accq.pop_front());
          end
        end
      end else if (accq.size() != 0 && sb.size() != 0 && cyc - accq[0] > sb[0].lat) begin
        chk($sformatf("op%0d_latency_late", sb[0].op), cyc - accq[0], sb[0].lat);
        void'(sb.pop_front());
        void'(accq.pop_front());
      end
      if (bus.in_valid && bus.in_ready) accq.push_back(cyc);
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end
  task automatic issue(int op, int a, int b, int c);
    bus.in_valid = 1'b1;
    bus.opcode = 3'(op);
    bus.a = 8'(a);
    bus.b = 8'(b);
    bus.cin = 1'(c);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(op, a, b, c));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.cin = 1'($urandom);
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.opcode = '0;
    bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    issue(0, 'hFF, 'h01, 0);
    issue(0, 'h01, 'h01, 1);
    issue(1, 'h80, 'h01, 1);
    issue(1, 'h00, 'h01, 0);
    issue(5, 'h0D, 'h0B, 0);
    issue(5, 'h10, 'h10, 0);
    issue(2, 'hF0, 'h3C, 0);
    issue(3, 'hF0, 'h3C, 0);
    issue(4, 'hF0, 'h3C, 0);
    issue(6, 'h81, 'h09, 0);
    issue(7, 'h81, 'h07, 0);
    rmode = 1;
    issue(0, 'h10, 'h20, 0);
    repeat (6) begin @(posedge clk); #1; end
    rmode = 2;
    issue(0, 'h02, 'h03, 0);
    issue(5, 'h0D, 'h0B, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(0, 'h21, 'h12, 0);
    rmode = 0;
    for (int n = 0; n < 300; n++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rmode = 2;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
